// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters.
// Registered decoder selects/enables, hold-limit preemption and a one-cycle dead gap.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       dec_c,
    output logic       dec_b,
    output logic       dec_a,
    output logic       dec_g,
    output logic       dec_g2a,
    output logic       dec_g2b,
    output logic [7:0] gnt_n,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [2:0] r_last;
    logic [7:0] r_hold;
    logic [2:0] r_sel;
    logic       r_g;
    logic       r_g2a;
    logic [7:0] r_gnt_n;
    logic       r_busy;

    logic [1:0] w_state_nx;
    logic [2:0] w_idx_nx;
    logic [2:0] w_last_nx;
    logic [7:0] w_hold_nx;
    logic [2:0] w_pick;
    logic [2:0] w_j;
    logic       w_found;
    logic       w_others;

    // First requester after r_last, scanning upward with wrap 7 -> 0.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            w_j = 3'(32'(r_last) + k);
            if (!w_found && req[w_j]) begin
                w_pick  = w_j;
                w_found = 1'b1;
            end
        end
    end

    assign w_others = |(req & ~(8'b1 << r_idx));

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_last_nx  = r_last;
        w_hold_nx  = r_hold;
        case (r_state)
            S_GRANT: begin
                if (!req[r_idx]) begin
                    w_last_nx  = r_idx;
                    w_state_nx = S_GAP;
                end else if (r_hold == HOLD_LAST && w_others) begin
                    w_last_nx  = r_idx;
                    w_state_nx = S_GAP;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold_nx = r_hold + 8'd1;
                end
            end
            default: begin
                if (w_found) begin
                    w_idx_nx   = w_pick;
                    w_hold_nx  = '0;
                    w_state_nx = S_GRANT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= 3'd7;
            r_hold  <= '0;
            r_sel   <= '0;
            r_g     <= 1'b0;
            r_g2a   <= 1'b1;
            r_gnt_n <= '1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_last  <= w_last_nx;
            r_hold  <= w_hold_nx;
            r_g     <= (w_state_nx == S_GRANT);
            r_g2a   <= (w_state_nx != S_GRANT);
            r_busy  <= (w_state_nx == S_GRANT);
            if (w_state_nx == S_GRANT) begin
                r_sel   <= w_idx_nx;
                r_gnt_n <= ~(8'b1 << w_idx_nx);
            end else begin
                r_gnt_n <= '1;
            end
        end
    end

    assign dec_c   = r_sel[2];
    assign dec_b   = r_sel[1];
    assign dec_a   = r_sel[0];
    assign dec_g   = r_g;
    assign dec_g2a = r_g2a;
    assign dec_g2b = 1'b0;
    assign gnt_n   = r_gnt_n;
    assign busy    = r_busy;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench: directed stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the matching DUT.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;

    logic       c0, b0, a0, g0, g2a0, g2b0, busy0;
    logic [7:0] gnt_n0;
    logic       c1, b1, a1, g1, g2a1, g2b1, busy1;
    logic [7:0] gnt_n1;

    rr_decoder_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .dec_c(c0), .dec_b(b0), .dec_a(a0),
        .dec_g(g0), .dec_g2a(g2a0), .dec_g2b(g2b0),
        .gnt_n(gnt_n0), .busy(busy0)
    );

    rr_decoder_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .dec_c(c1), .dec_b(b1), .dec_a(a1),
        .dec_g(g1), .dec_g2a(g2a1), .dec_g2b(g2b1),
        .gnt_n(gnt_n1), .busy(busy1)
    );

    typedef struct {
        int unsigned cyc;
        bit          dut;
        logic [7:0]  gnt_n;
        logic        g;
        logic [2:0]  sel;
        bit          chk_sel;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    bit          cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp, input int unsigned c);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] gn;
            logic [2:0] s;
            logic g, g2a, g2b, bz;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc, cyc, e.cyc);
            end else begin
                if (e.dut) begin
                    gn = gnt_n1; s = {c1, b1, a1}; g = g1; g2a = g2a1; g2b = g2b1; bz = busy1;
                end else begin
                    gn = gnt_n0; s = {c0, b0, a0}; g = g0; g2a = g2a0; g2b = g2b0; bz = busy0;
                end
                chk("gnt_n",   gn,         e.gnt_n,       e.cyc);
                chk("dec_g",   8'(g),      8'(e.g),       e.cyc);
                chk("dec_g2a", 8'(g2a),    8'(!e.g),      e.cyc);
                chk("dec_g2b", 8'(g2b),    8'h00,         e.cyc);
                chk("busy",    8'(bz),     8'(e.g),       e.cyc);
                if (e.chk_sel) chk("dec_cba", 8'(s), 8'(e.sel), e.cyc);
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] gn,
                        input logic g, input logic [2:0] s, input bit cs);
        exp_t e;
        rst = r;
        req = rq;
        e = '{cyc: cyc + 1, dut: cur, gnt_n: gn, g: g, sel: s, chk_sel: cs};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic gr(input logic [7:0] rq, input logic [2:0] i);
        step(1'b0, rq, ~(8'b1 << i), 1'b1, i, 1'b1);
    endtask

    task automatic ng(input logic [7:0] rq);
        step(1'b0, rq, 8'hFF, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic ng_sel0(input logic [7:0] rq);
        step(1'b0, rq, 8'hFF, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic rs(input logic [7:0] rq);
        step(1'b1, rq, 8'hFF, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur = 1'b0;
        rst = 1'b1;
        req = 8'h00;
        @(posedge clk);
        #1;

        rs(8'h00);
        repeat (5) ng_sel0(8'h00);

        repeat (4) gr(8'h24, 3'd2);
        ng(8'h24);
        repeat (4) gr(8'h24, 3'd5);
        ng(8'h24);
        gr(8'h24, 3'd2);

        ng(8'h00);
        ng(8'h00);
        repeat (20) gr(8'h08, 3'd3);

        ng(8'h00);
        ng(8'h00);
        gr(8'h01, 3'd0);
        gr(8'h81, 3'd0);
        ng(8'h80);
        gr(8'h80, 3'd7);
        ng(8'h03);
        gr(8'h03, 3'd0);

        ng(8'h00);
        ng(8'h00);
        gr(8'h40, 3'd6);
        gr(8'h40, 3'd6);
        rs(8'h40);
        ng_sel0(8'h00);
        repeat (4) gr(8'h41, 3'd0);
        ng(8'h41);
        gr(8'h41, 3'd6);

        cur = 1'b1;
        rs(8'h00);
        for (int i = 0; i < 8; i++) begin
            gr(8'hFF, 3'(i));
            ng(8'hFF);
        end
        gr(8'hFF, 3'd0);

        req = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
